// File: rtl/clk_div_ctrl.sv
// Run-time divide-by-N controller: divided clock level, period-start tick, and
// config handshake applied only at period boundaries. Optional: CLK_DIV_CTRL_PERIOD_CNT_EN.
module clk_div_ctrl #(
   parameter int W        = 8,
   parameter int DEF_DIV  = 5,
   parameter int DEF_HIGH = 2
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         en,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_div,
   input  logic [W-1:0] cfg_high,
   output logic         cfg_ready,
   output logic         cfg_err,
   output logic         clk_div,
   output logic         tick,
   output logic         busy,
   output logic [W-1:0] cur_div
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   ,
   output logic [15:0]  period_cnt
`endif
);

   localparam logic [W-1:0] DEF_DIV_W  = W'(DEF_DIV);
   localparam logic [W-1:0] DEF_HIGH_W = W'(DEF_HIGH);

   typedef enum logic [1:0] {IDLE, RUN, PEND, DRAIN} state_t;

   state_t       state, state_next;
   logic [W-1:0] cnt, cnt_inc;
   logic [W-1:0] div_act, high_act;
   logic [W-1:0] shadow_div, shadow_high;
   logic         shadow_full;
   logic         xfer, legal, xfer_ok, boundary, stop;

   assign cfg_ready = ((state == IDLE) || (state == RUN)) && !rst;
   assign busy      = (state != IDLE);
   assign cur_div   = div_act;

   always_comb begin
      xfer       = cfg_valid && cfg_ready;
      legal      = (cfg_div >= W'(2)) && (cfg_high != '0) && (cfg_high < cfg_div);
      xfer_ok    = xfer && legal;
      boundary   = (cnt == div_act - W'(1));
      cnt_inc    = cnt + W'(1);
      stop       = (state == DRAIN) && !en && boundary;
      state_next = state;
      case (state)
         IDLE:  if (en) state_next = RUN;
         RUN: begin
            if (!en)          state_next = DRAIN;
            else if (xfer_ok) state_next = PEND;
         end
         PEND: begin
            if (!en)           state_next = DRAIN;
            else if (boundary) state_next = RUN;
         end
         DRAIN: begin
            // A pending shadow is committed at the boundary, so resuming there lands in RUN.
            if (!en)                            state_next = boundary ? IDLE : DRAIN;
            else if (shadow_full && !boundary)  state_next = PEND;
            else                                state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt         <= '0;
         div_act     <= DEF_DIV_W;
         high_act    <= DEF_HIGH_W;
         shadow_div  <= '0;
         shadow_high <= '0;
         shadow_full <= 1'b0;
         clk_div     <= 1'b0;
         tick        <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         cfg_err <= xfer && !legal;
         tick    <= 1'b0;
         if (state == IDLE) begin
            if (xfer_ok) begin
               div_act  <= cfg_div;
               high_act <= cfg_high;
            end
            if (en) begin
               cnt     <= '0;
               clk_div <= 1'b1;
               tick    <= 1'b1;
            end
         end else if (boundary) begin
            // Period complete: swap in any shadow config before the next period begins.
            if (shadow_full) begin
               div_act     <= shadow_div;
               high_act    <= shadow_high;
               shadow_full <= 1'b0;
            end
            cnt     <= '0;
            clk_div <= !stop;
            tick    <= !stop;
         end else begin
            cnt     <= cnt_inc;
            clk_div <= (cnt_inc < high_act);
         end
         if ((state == RUN) && xfer_ok) begin
            shadow_div  <= cfg_div;
            shadow_high <= cfg_high;
            shadow_full <= 1'b1;
         end
      end
   end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   always_ff @(posedge clk_in) begin
      if (rst || ((state == IDLE) && en))       period_cnt <= '0;
      else if (tick && (period_cnt != 16'hFFFF)) period_cnt <= period_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the divide-by-N clock-enable generators (e.g. the divide-by-5 block).
- Holds the active divide ratio and high-time, and generates the divided clock level plus a period-start tick.
- Accepts new ratio/duty configurations over a valid/ready handshake.
- Applies a new configuration, and handles enable/disable, only at period boundaries, so no runt or stretched pulse ever appears on the divided output.

Parameters:
W, 8, width of divide ratio and high-time fields
DEF_DIV, 5, divide ratio loaded at reset
DEF_HIGH, 2, high-time (cycles) loaded at reset

Ports:
clk_in  input  1  single system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  level; 1 = run divider, 0 = stop at end of current period
cfg_valid  input  1  config request valid
cfg_div  input  W  requested divide ratio N
cfg_high  input  W  requested high-time H (cycles)
cfg_ready  output  1  controller can accept config this cycle
cfg_err  output  1  one-cycle pulse: last accepted-handshake config was illegal
clk_div  output  1  divided clock level (registered)
tick  output  1  one-cycle pulse on the first cycle of each period (registered)
busy  output  1  1 in any state except IDLE
cur_div  output  W  active divide ratio

Behaviour:
- Reset (rst=1 at edge): state IDLE, cnt=0, div_act=DEF_DIV, high_act=DEF_HIGH, shadow empty, clk_div=0, tick=0, cfg_err=0, busy=0, cur_div=DEF_DIV.
- States: IDLE, RUN, PEND (run with shadow config waiting), DRAIN (en low, finishing period).
- cfg_ready = 1 in IDLE and RUN; 0 in PEND and DRAIN and during rst.
- Transfer occurs when cfg_valid && cfg_ready.
- Legal config: N >= 2 and 1 <= H <= N-1. Illegal transfer: discarded, cfg_err=1 the next cycle, state unchanged.
- Legal transfer in IDLE: written directly to div_act/high_act (cur_div updates the next cycle).
- Legal transfer in RUN: written to shadow; state goes to PEND.
- IDLE -> RUN when en=1. On that edge: cnt=0, clk_div=1, tick=1. First period starts 1 cycle after en is sampled.
- RUN/PEND counting: cnt increments each cycle. At boundary (cnt == div_act-1): cnt wraps to 0 and tick=1.
- clk_div is registered: 1 when next cnt < high_act, else 0. Period = div_act cycles; high = high_act cycles.
- PEND at boundary: div_act/high_act <= shadow, shadow cleared, state -> RUN. The new period uses the new values starting at cnt=0. The old period always completes in full.
- en=0 in RUN or PEND: state -> DRAIN; the current period continues unchanged.
- DRAIN at boundary with en=0: pending shadow (if any) is committed, state -> IDLE, clk_div=0, tick=0, cnt=0.
- DRAIN with en=1 again before the boundary: return to PEND if shadow is full, else RUN. No disturbance to cnt or clk_div.
- Simultaneous legal transfer and en falling in RUN: config goes to shadow, state -> DRAIN, shadow committed at the boundary.
- Reset mid-period: all state returns to reset values on that edge. clk_div drops to 0 with no completion of the period.
- Counter width W; div_act=2^W-1 is legal; no overflow occurs since cnt < div_act.

Optional Feature:
CLK_DIV_CTRL_PERIOD_CNT_EN
- When defined: adds output period_cnt [15:0].
  - Increments on every tick.
  - Saturates at 16'hFFFF.
  - Cleared by rst and on each IDLE -> RUN transition.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, en=1, no config -> tick every 5 cycles; clk_div pattern 1,1,0,0,0 repeating; cur_div=5; busy=1.
- In RUN at cnt=1, write N=3,H=1 -> cfg_ready drops next cycle; old 5-cycle period completes (clk_div 1,1,0,0,0); then 1,0,0 repeating; cur_div=3 from the boundary.
- Write N=1,H=1 (then N=4,H=4) in IDLE -> cfg_err pulses 1 cycle each; cur_div stays 5.
- en=0 at cnt=2 of N=5 -> clk_div finishes 0,0 to the boundary, then stays 0; tick stops; busy=0 after the boundary.
- en=0 then en=1 two cycles later within the same period -> no gap in the pattern; tick interval stays 5; state returns to RUN.
- rst=1 at cnt=1 with shadow full (N=3) -> next cycle clk_div=0, cur_div=5, cfg_ready=1, shadow discarded.
